// File: rtl/fifo_uart_tx.sv
// FIFO drain-side UART transmitter: pops one byte per frame from a FWFT FIFO and sends it 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int Bits       = 8,
    parameter int ClksPerBit = 868,
    parameter int CntWidth   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [Bits-1:0] fifo_dout,
    output logic            fifo_rd,
    output logic            tx,
    output logic            busy,
    output logic            tx_done
);

    localparam int IdxWidth = (Bits > 1) ? $clog2(Bits) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(ClksPerBit - 1);
    localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(Bits - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {SYNC, IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {SYNC, IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_reg;
    logic [CntWidth-1:0]   cnt_reg;
    logic [IdxWidth-1:0]   bit_idx_reg;
    logic [Bits-1:0]       shift_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  tx_done_reg;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_reg;
`endif

    logic baud_tick;
    assign baud_tick = (cnt_reg == CntLast);

    // Gated by reset so no byte is popped on an edge that is about to abort the frame.
    assign fifo_rd = ~reset & (state_reg == IDLE) & ~fifo_empty;

    assign tx      = tx_reg;
    assign busy    = busy_reg;
    assign tx_done = tx_done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= SYNC;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            tx_done_reg <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                // FIFO flags are not trustworthy until its own init cycle is over.
                SYNC: state_reg <= IDLE;
                IDLE: begin
                    if (fifo_rd) begin
                        shift_reg <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity_reg <= ^fifo_dout;
`endif
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == IdxLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
`endif
                        end else begin
                            // shift_reg[1] is the bit that lands in position 0 after this shift
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        cnt_reg   <= '0;
                        tx_reg    <= 1'b1;
                        state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        cnt_reg     <= '0;
                        busy_reg    <= 1'b0;
                        tx_done_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at ClksPerBit=4: reset/SYNC behaviour, single and back-to-back frames,
// mid-frame reset and FIFO flag/data changes during a frame.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int total = 0;
    int bad = 0;
    int rd_count = 0;
    int rd_base = 0;

    fifo_uart_tx #(
        .Bits(8),
        .ClksPerBit(CPB),
        .CntWidth(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd),
        .tx(tx),
        .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fifo_rd === 1'b1) rd_count <= rd_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit slot idx: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entry: at the sample point of an IDLE cycle with byte b presented. Returns at the tx_done cycle.
    task automatic frame(input logic [7:0] b, input logic nxt_empty, input logic [7:0] nxt_dout,
                         input logic toggle);
        chk($sformatf("launch_rd_%02h", b), fifo_rd, 1);
        for (int k = 0; k < FB * CPB; k++) begin
            @(negedge clk);
            if (k == 0) begin
                fifo_empty = nxt_empty;
                fifo_dout  = nxt_dout;
            end
            if (toggle && k == 12) begin
                fifo_empty = 1'b1;
                fifo_dout  = ~b;
            end
            if (toggle && k == 24) begin
                fifo_empty = nxt_empty;
                fifo_dout  = nxt_dout;
            end
            #1;
            chk($sformatf("tx_%02h_k%0d", b, k), tx, exp_bit(b, k / CPB));
            chk($sformatf("busy_%02h_k%0d", b, k), busy, 1);
            chk($sformatf("rd_%02h_k%0d", b, k), fifo_rd, 0);
            chk($sformatf("done_%02h_k%0d", b, k), tx_done, 0);
        end
        @(negedge clk);
        #1;
        chk($sformatf("tx_done_%02h", b), tx_done, 1);
        chk($sformatf("busy_end_%02h", b), busy, 0);
        chk($sformatf("tx_end_%02h", b), tx, 1);
        chk($sformatf("rd_idle_%02h", b), fifo_rd, {31'd0, ~nxt_empty});
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_done", tx_done, 0);

        // Empty FIFO for 100 clks
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            chk("empty_tx", tx, 1);
            chk("empty_busy", busy, 0);
            chk("empty_rd", fifo_rd, 0);
        end

        // Data offered during the SYNC cycle must not be popped
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fifo_empty = 1'b0;
        fifo_dout = 8'hA5;
        #1;
        chk("sync_no_pop", fifo_rd, 0);
        chk("sync_tx", tx, 1);

        @(negedge clk);
        #1;
        frame(8'hA5, 1'b1, 8'h00, 1'b0);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("gap_tx", tx, 1);
            chk("gap_rd", fifo_rd, 0);
        end

        // Three queued bytes back to back
        rd_base = rd_count;
        fifo_empty = 1'b0;
        fifo_dout = 8'h00;
        #1;
        frame(8'h00, 1'b0, 8'hFF, 1'b0);
        frame(8'hFF, 1'b0, 8'h3C, 1'b0);
        frame(8'h3C, 1'b1, 8'h00, 1'b0);
        chk("three_pops", rd_count - rd_base, 3);

        // Reset 13 clks into a frame of 8'h55, 8'hC3 queued behind it
        @(negedge clk);
        fifo_empty = 1'b0;
        fifo_dout = 8'h55;
        #1;
        chk("launch_rd_55", fifo_rd, 1);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 0) fifo_dout = 8'hC3;
            #1;
            chk($sformatf("tx_55_k%0d", k), tx, exp_bit(8'h55, k / CPB));
            chk("rd_55", fifo_rd, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_sync_rd", fifo_rd, 0);
        @(negedge clk);
        #1;
        frame(8'hC3, 1'b1, 8'h00, 1'b0);

        // Flags and head word changing mid-frame
        @(negedge clk);
        fifo_empty = 1'b0;
        fifo_dout = 8'h96;
        #1;
        frame(8'h96, 1'b0, 8'h22, 1'b1);
        frame(8'h22, 1'b1, 8'h00, 1'b0);
        chk("total_pops", rd_count, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
